// File: rtl/dsm_pkg.sv
// Shared constants, FSM state type and saturating clamp for the second-order
// delta-sigma modulator.
package dsm_pkg;
    localparam int DW      = 12;
    localparam int IW      = 16;
    localparam int MW      = 10;
    localparam int FS      = 1 << (DW - 1);
    localparam int INT_MAX = (1 << (IW - 1)) - 1;
    // int2 + int1_next + FS can reach 2*INT_MAX + FS, which needs two guard bits.
    localparam int SW      = IW + 2;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    typedef struct packed {
        logic                 clip;
        logic signed [IW-1:0] val;
    } sat_t;

    // Symmetric clamp to +/-INT_MAX; clip reports that the clamp engaged.
    function automatic sat_t sat(input logic signed [SW-1:0] v);
        sat_t                 r;
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        hi = SW'(INT_MAX);
        lo = -hi;
        r.clip = 1'b0;
        r.val  = v[IW-1:0];
        if (v > hi) begin
            r.clip = 1'b1;
            r.val  = hi[IW-1:0];
        end else if (v < lo) begin
            r.clip = 1'b1;
            r.val  = lo[IW-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/dsm2_mod_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the second
// clk edge after rstb_raw rises.
module rst_sync (
    input  logic clk,
    input  logic rstb_raw,
    output logic rstb
);
    logic meta;

    always_ff @(posedge clk or negedge rstb_raw) begin
        if (!rstb_raw) begin
            meta <= 1'b0;
            rstb <= 1'b0;
        end else begin
            meta <= 1'b1;
            rstb <= meta;
        end
    end
endmodule

// File: rtl/dsm2_mod.sv
// Second-order delta-sigma modulator: turns one held sample into 2*M+1
// bitstream bits per start, with saturating integrators and a sticky ovf.
module dsm2_mod
    import dsm_pkg::*;
(
    input  logic          clk,
    input  logic          rstb_raw,
    input  logic          start,
    input  logic [MW-1:0] M_in,
    input  logic [DW-1:0] x_in,
    output logic          bit_out,
    output logic          bit_valid,
    output logic          busy,
    output logic          done,
    output logic          ovf
);
    logic rstb;

    rst_sync u_rst_sync (
        .clk      (clk),
        .rstb_raw (rstb_raw),
        .rstb     (rstb)
    );

    state_t               state;
    logic signed [DW-1:0] x_r;
    logic        [MW-1:0] m_r;
    logic        [MW:0]   cnt;
    logic signed [IW-1:0] int1;
    logic signed [IW-1:0] int2;

    logic                 q;
    logic signed [SW-1:0] fb;
    logic signed [SW-1:0] sum1;
    logic signed [SW-1:0] sum2;
    sat_t                 s1;
    sat_t                 s2;

    // int2 integrates the already-updated int1, so both stages settle in one cycle.
    always_comb begin
        q    = ~int2[IW-1];
        fb   = q ? SW'(FS) : -SW'(FS);
        sum1 = SW'(int1) + SW'(x_r) - fb;
        s1   = sat(sum1);
        sum2 = SW'(int2) + SW'($signed(s1.val)) - fb;
        s2   = sat(sum2);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            x_r       <= '0;
            m_r       <= '0;
            cnt       <= '0;
            int1      <= '0;
            int2      <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x_r  <= x_in;
                    m_r  <= M_in;
                    cnt  <= '0;
                    int1 <= '0;
                    int2 <= '0;
                    ovf  <= 1'b0;
                    done <= 1'b0;
                    if (M_in == '0) begin
                        state <= FIN;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    int1      <= s1.val;
                    int2      <= s2.val;
                    ovf       <= ovf | s1.clip | s2.clip;
                    bit_out   <= q;
                    bit_valid <= 1'b1;
                    cnt       <= cnt + 1'b1;
                    if (cnt == {m_r, 1'b0})
                        state <= FIN;
                end
                FIN: begin
                    bit_valid <= 1'b0;
                    bit_out   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsm2_mod.sv
// Self-checking bench for dsm2_mod: vector table, hand-written corner
// sequences and random samples compared against an integer reference model.
module tb_dsm2_mod;
    import dsm_pkg::*;

    logic          clk;
    logic          rstb_raw;
    logic          start;
    logic [MW-1:0] M_in;
    logic [DW-1:0] x_in;
    logic          bit_out;
    logic          bit_valid;
    logic          busy;
    logic          done;
    logic          ovf;

    dsm2_mod dut (
        .clk       (clk),
        .rstb_raw  (rstb_raw),
        .start     (start),
        .M_in      (M_in),
        .x_in      (x_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference results for the conversion under test.
    bit mbits[$];
    bit movf;

    // Observation results.
    int nv, first, last, ones, mism, done_at;
    bit busy_at_done, ovf_at_done;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic int clampv(input int v);
        if (v > INT_MAX) begin
            movf = 1'b1;
            return INT_MAX;
        end
        if (v < -INT_MAX) begin
            movf = 1'b1;
            return -INT_MAX;
        end
        return v;
    endfunction

    // Two cascaded accumulators with +/-FS feedback from the sign of the second.
    function automatic void model(input int x, input int m);
        int a, b, f, n;
        bit y;
        a = 0;
        b = 0;
        movf = 1'b0;
        mbits.delete();
        n = (m == 0) ? 0 : 2 * m + 1;
        for (int k = 0; k < n; k++) begin
            y = (b >= 0);
            f = y ? FS : -FS;
            a = clampv(a + x - f);
            b = clampv(b + a - f);
            mbits.push_back(y);
        end
    endfunction

    // Presents start for exactly one edge; returns 1ns after that edge.
    task automatic launch(input int x, input int m);
        x_in  = DW'(x);
        M_in  = MW'(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Watches a fixed number of edges after the start edge; optional start
    // pokes at edges pa/pb exercise the ignore-while-busy path.
    task automatic observe(input int edges, input int pa, input int pb);
        nv = 0; first = -1; last = -1; ones = 0; mism = 0; done_at = -1;
        busy_at_done = 1'b1; ovf_at_done = 1'b0;
        for (int e = 1; e <= edges; e++) begin
            start = (e == pa) || (e == pb);
            if (start) M_in = MW'(7);
            @(posedge clk); #1;
            start = 1'b0;
            if (bit_valid) begin
                if (first < 0) first = e;
                last = e;
                if (nv >= mbits.size() || bit_out != mbits[nv]) mism++;
                ones += int'(bit_out);
                nv++;
            end
            if (done && done_at < 0) begin
                done_at = e;
                busy_at_done = busy;
                ovf_at_done = ovf;
            end
        end
    endtask

    task automatic run_vec(input string tag, input int x, input int m,
                           input int lo, input int hi, input bit need_ovf0);
        int n;
        n = (m == 0) ? 0 : 2 * m + 1;
        model(x, m);
        launch(x, m);
        chk({tag, " busy after start"}, busy, m != 0);
        chk({tag, " done cleared by start"}, done, 0);
        observe(2 * m + 6, -1, -1);
        chk({tag, " bit count"}, nv, n);
        chk({tag, " first bit edge"}, first, (m != 0) ? 1 : -1);
        chk({tag, " last bit edge"}, last, (m != 0) ? 2 * m + 1 : -1);
        chk({tag, " bit mismatches"}, mism, 0);
        chk({tag, " done edge"}, done_at, (m != 0) ? 2 * m + 2 : 1);
        chk({tag, " busy at done"}, busy_at_done, 0);
        chk({tag, " ovf vs model"}, ovf_at_done, movf);
        if (n > 0) chk_rng({tag, " ones density"}, ones, lo, hi);
        if (need_ovf0) chk({tag, " ovf clear"}, ovf_at_done, 0);
    endtask

    typedef struct {
        int x;
        int m;
        int lo;
        int hi;
        bit ovf0;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   bad, busy_first, x, m;

        vt[0] = '{0,     4,   0,   9,    1'b1};
        vt[1] = '{0,     256, 254, 259,  1'b1};
        vt[2] = '{1024,  256, 381, 389,  1'b1};
        vt[3] = '{-1024, 256, 124, 132,  1'b1};
        vt[4] = '{0,     0,   0,   0,    1'b1};
        vt[5] = '{2047,  512, 0,   1025, 1'b0};

        rstb_raw = 1'b0;
        start    = 1'b0;
        M_in     = '0;
        x_in     = '0;

        // Reset held: start pulses must produce nothing.
        bad = 0;
        for (int e = 0; e < 6; e++) begin
            start = e[0];
            M_in  = MW'(4);
            @(posedge clk); #1;
            if (bit_valid || busy || done || ovf || bit_out) bad++;
        end
        chk("outputs quiet in reset", bad, 0);

        // Release with start held high: first acceptance on the 3rd edge.
        rstb_raw   = 1'b1;
        start      = 1'b1;
        M_in       = MW'(1);
        x_in       = '0;
        busy_first = -1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (busy && busy_first < 0) busy_first = e;
        end
        start = 1'b0;
        chk("first accepted edge after release", busy_first, 3);
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vt[i].x, vt[i].m, vt[i].lo, vt[i].hi, vt[i].ovf0);

        // start during RUN and during FIN is ignored.
        model(0, 4);
        launch(0, 4);
        observe(16, 3, 10);
        chk("busy start: bit count", nv, 9);
        chk("busy start: mismatches", mism, 0);
        chk("busy start: done edge", done_at, 10);

        // Back-to-back: start in the first cycle done is high.
        model(300, 3);
        launch(300, 3);
        observe(8, -1, -1);
        chk("b2b: first done edge", done_at, 8);
        model(-300, 2);
        launch(-300, 2);
        chk("b2b: done drops", done, 0);
        chk("b2b: busy rises", busy, 1);
        observe(10, -1, -1);
        chk("b2b: second bit count", nv, 5);
        chk("b2b: second mismatches", mism, 0);
        chk("b2b: second done edge", done_at, 6);

        // Random samples within the stable range.
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(3072)) - 1536;
            m = int'($urandom_range(40, 1));
            run_vec($sformatf("rnd%0d x=%0d m=%0d", i, x, m), x, m, 0, 2 * m + 1, 1'b1);
        end

        // Reset mid-RUN aborts at once and leaves done low.
        model(0, 20);
        launch(0, 20);
        repeat (5) @(posedge clk);
        #1;
        rstb_raw = 1'b0;
        #1;
        chk("abort: bit_valid", bit_valid, 0);
        chk("abort: busy", busy, 0);
        chk("abort: done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        rstb_raw = 1'b1;
        bad = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (bit_valid || done || busy) bad++;
        end
        chk("abort: quiet after release", bad, 0);
        run_vec("recover", 512, 8, 0, 17, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
